// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential FP significand multiplier.
// Used by mult_unpack and mult_seq_core.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned BIAS        = 127;
    localparam int unsigned EXP_SPECIAL = 300;
    localparam int unsigned MANT_W      = 24;
    localparam int unsigned PROD_W      = 48;

    // Biased product exponent for two normal operands; negative results clamp to 0.
    function automatic logic [9:0] biased_exp_sum(input logic [7:0] ea, input logic [7:0] eb);
        logic signed [10:0] sum;
        sum = $signed({3'b000, ea}) + $signed({3'b000, eb}) - $signed(11'(BIAS));
        return sum[10] ? '0 : sum[9:0];
    endfunction

endpackage

// File: rtl/mult_unpack.sv
// Combinational IEEE-754 single unpacker: sign, exponent field, significand
// with hidden bit, and zero (subnormals flushed) / special (Inf or NaN) flags.
module mult_unpack
    import mult_pkg::*;
(
    input  logic [31:0]       op,
    output logic              sign,
    output logic [7:0]        exp_f,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_special
);

    always_comb begin
        sign       = op[31];
        exp_f      = op[30:23];
        is_zero    = (op[30:23] == 8'h00);
        is_special = (op[30:23] == 8'hFF);
        mant       = {~is_zero, op[22:0]};
    end

endmodule

// File: rtl/mult_seq_core.sv
// Sequential shift-add significand multiplier feeding a downstream normaliser.
// Define MULT_SEQ_EARLY_EXIT_EN to send zero/special operands straight to DONE.
module mult_seq_core
    import mult_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sign,
    output logic [9:0]  exp_sum,
    output logic [47:0] mant_prod,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned ITERS = MANT_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [MANT_W-1:0] mplier_q, mplier_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic              res_sign_q, res_sign_d;
    logic [9:0]        res_exp_q, res_exp_d;
    logic              sign_q, sign_d;
    logic [9:0]        exp_sum_q, exp_sum_d;
    logic [PROD_W-1:0] mant_prod_q, mant_prod_d;
    logic              out_valid_q, out_valid_d;

    logic              sign_a, sign_b, zero_a, zero_b, spec_a, spec_b;
    logic [7:0]        exp_a, exp_b;
    logic [MANT_W-1:0] mant_a, mant_b;

    mult_unpack u_unpack_a (
        .op        (a),
        .sign      (sign_a),
        .exp_f     (exp_a),
        .mant      (mant_a),
        .is_zero   (zero_a),
        .is_special(spec_a)
    );

    mult_unpack u_unpack_b (
        .op        (b),
        .sign      (sign_b),
        .exp_f     (exp_b),
        .mant      (mant_b),
        .is_zero   (zero_b),
        .is_special(spec_b)
    );

    logic              accept;
    logic              forced;
    logic [PROD_W-1:0] step_sum;

    always_comb begin
        accept   = in_valid && (state_q == IDLE);
        forced   = zero_a || zero_b || spec_a || spec_b;
        step_sum = acc_q;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        res_sign_d  = res_sign_q;
        res_exp_d   = res_exp_q;
        sign_d      = sign_q;
        exp_sum_d   = exp_sum_q;
        mant_prod_d = mant_prod_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    res_sign_d = sign_a ^ sign_b;
                    if (zero_a || zero_b)      res_exp_d = '0;
                    else if (spec_a || spec_b) res_exp_d = 10'(EXP_SPECIAL);
                    else                       res_exp_d = biased_exp_sum(exp_a, exp_b);
                    // A zero multiplier forces the accumulated product to 0.
                    mcand_d  = PROD_W'(mant_a);
                    mplier_d = forced ? '0 : mant_b;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
                    state_d  = forced ? DONE : CALC;
`else
                    state_d  = CALC;
`endif
                end
            end
            CALC: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle loads the result registers; handshake only once valid.
                if (!out_valid_q) begin
                    sign_d      = res_sign_q;
                    exp_sum_d   = res_exp_q;
                    mant_prod_d = acc_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            res_sign_q  <= 1'b0;
            res_exp_q   <= '0;
            sign_q      <= 1'b0;
            exp_sum_q   <= '0;
            mant_prod_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            res_sign_q  <= res_sign_d;
            res_exp_q   <= res_exp_d;
            sign_q      <= sign_d;
            exp_sum_q   <= exp_sum_d;
            mant_prod_q <= mant_prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign sign      = sign_q;
    assign exp_sum   = exp_sum_q;
    assign mant_prod = mant_prod_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_seq_core.sv
// Scoreboard bench for mult_seq_core: a BITS_PER_CYCLE=1 and a =4 instance
// share stimulus; expected results are queued at accept and checked on out_valid.
module tb_mult_seq_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy1, v1, s1;
    logic [9:0]  e1;
    logic [47:0] m1;
    logic        rdy4, v4, s4;
    logic [9:0]  e4;
    logic [47:0] m4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t cur1, cur4;
    bit   busy1 = 0, busy4 = 0, good1 = 0, good4 = 0;

    mult_seq_core #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy1),
        .sign(s1), .exp_sum(e1), .mant_prod(m1), .out_valid(v1), .out_ready(out_ready)
    );

    mult_seq_core #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy4),
        .sign(s4), .exp_sum(e4), .mant_prod(m4), .out_valid(v4), .out_ready(out_ready)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor for the 1-bit-per-cycle instance.
    always @(negedge clk) begin
        if (!v1) begin
            busy1 = 0;
        end else begin
            if (!busy1) begin
                busy1 = 1;
                good1 = (q1.size() != 0);
                if (!good1) begin
                    tests++;
                    fails++;
                    $display("FAIL b1_unexpected_valid: got out_valid=1, expected no pending result");
                end else begin
                    cur1 = q1.pop_front();
                    check("b1_latency", 64'(cyc - cur1.acc), 64'(cur1.lat));
                end
            end
            if (good1) begin
                check("b1_sign", 64'(s1), 64'(cur1.s));
                check("b1_exp_sum", 64'(e1), 64'(cur1.e));
                check("b1_mant_prod", 64'(m1), 64'(cur1.m));
                check("b1_in_ready_low", 64'(rdy1), 64'd0);
            end
        end
    end

    // Monitor for the 4-bits-per-cycle instance.
    always @(negedge clk) begin
        if (!v4) begin
            busy4 = 0;
        end else begin
            if (!busy4) begin
                busy4 = 1;
                good4 = (q4.size() != 0);
                if (!good4) begin
                    tests++;
                    fails++;
                    $display("FAIL b4_unexpected_valid: got out_valid=1, expected no pending result");
                end else begin
                    cur4 = q4.pop_front();
                    check("b4_latency", 64'(cyc - cur4.acc), 64'(cur4.lat));
                end
            end
            if (good4) begin
                check("b4_sign", 64'(s4), 64'(cur4.s));
                check("b4_exp_sum", 64'(e4), 64'(cur4.e));
                check("b4_mant_prod", 64'(m4), 64'(cur4.m));
                check("b4_in_ready_low", 64'(rdy4), 64'd0);
            end
        end
    end

    // Returns at a negedge with both instances idle, or flags a timeout.
    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(rdy1 && rdy4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got in_ready=%0b/%0b after %0d cycles, expected 1/1", name, rdy1, rdy4, n);
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic es,
                         input logic [9:0] ee, input logic [47:0] em, input bit forced);
        exp_t t;
        wait_idle("issue");
        #1;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        t.s   = es;
        t.e   = ee;
        t.m   = em;
        t.acc = cyc;
        t.lat = (forced && EARLY) ? 1 : 25;
        q1.push_back(t);
        t.lat = (forced && EARLY) ? 1 : 7;
        q4.push_back(t);
        // Operand and valid changes after the accept must not disturb the result.
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_in_ready_b1", 64'(rdy1), 64'd1);
        check("rst_out_valid_b1", 64'(v1), 64'd0);
        check("rst_outputs_b1", {5'd0, s1, e1, m1}, 64'd0);
        check("rst_in_ready_b4", 64'(rdy4), 64'd1);
        check("rst_out_valid_b4", 64'(v4), 64'd0);
        check("rst_outputs_b4", {5'd0, s4, e4, m4}, 64'd0);
        #1 rst_n = 1'b1;

        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 10'd127, 48'h4000_0000_0000, 1'b0);
        issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 10'd127, 48'h9000_0000_0000, 1'b0);
        issue(32'hC000_0000, 32'h4040_0000, 1'b1, 10'd129, 48'h6000_0000_0000, 1'b0);
        issue(32'h0000_0000, 32'h7F80_0000, 1'b0, 10'd0,   48'h0,              1'b1);
        issue(32'h7F80_0000, 32'h4000_0000, 1'b0, 10'd300, 48'h0,              1'b1);
        issue(32'h7FC0_0000, 32'hBF80_0000, 1'b1, 10'd300, 48'h0,              1'b1);

        // Backpressure: result must hold while out_ready stays low.
        wait_idle("pre_hold");
        #1 out_ready = 1'b0;
        issue(32'h0080_0000, 32'h0080_0000, 1'b0, 10'd0, 48'h4000_0000_0000, 1'b0);
        n = 0;
        @(negedge clk);
        while (!v1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 64'(v1), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("hold_in_ready_b1", 64'(rdy1), 64'd0);
            check("hold_valid_b1", 64'(v1), 64'd1);
            check("hold_valid_b4", 64'(v4), 64'd1);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drop_valid_b1", 64'(v1), 64'd0);
        check("drop_valid_b4", 64'(v4), 64'd0);

        // Reset pulse mid-CALC abandons the operation.
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 10'd128, 48'h4000_0000_0000, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid_b1", 64'(v1), 64'd0);
        check("midrst_in_ready_b1", 64'(rdy1), 64'd1);
        check("midrst_mant_b1", 64'(m1), 64'd0);
        q1.delete();
        q4.delete();
        #2 rst_n = 1'b1;
        issue(32'hC000_0000, 32'h4040_0000, 1'b1, 10'd129, 48'h6000_0000_0000, 1'b0);

        wait_idle("drain");
        repeat (3) @(negedge clk);
        check("drain_pending", 64'(q1.size() + q4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_seq_core.md
MULT_SEQ_CORE -- requirements
Module: mult_seq_core

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port a, input, 32, IEEE-754 single operand A.
REQ-005 SHALL have port b, input, 32, IEEE-754 single operand B.
REQ-006 SHALL have port in_valid, input, 1, operands valid.
REQ-007 SHALL have port in_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port sign, output, 1, a[31] XOR b[31].
REQ-009 SHALL have port exp_sum, output, 10, biased product exponent, before normalisation.
REQ-010 SHALL have port mant_prod, output, 48, raw 24x24 significand product.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream normaliser accepts.

Function
REQ-013 SHALL accept an operand pair on a rising edge with in_valid and in_ready both high, and SHALL capture a and b in the same edge.
REQ-014 SHALL use FSM states IDLE, CALC and DONE: IDLE->CALC on accept; CALC->DONE when the iteration count expires; DONE->IDLE on out_ready; no other transitions.
REQ-015 SHALL classify each operand with a zero field as zero (subnormals flushed) and each operand with field 255 as special (Inf and NaN both).
REQ-016 SHALL compute a normal x normal product as mant_prod = {1,fa} * {1,fb}, by shift-add, BITS_PER_CYCLE multiplier bits per CALC cycle, 24/BITS_PER_CYCLE CALC cycles.
REQ-017 SHALL compute exp_sum for a normal x normal product as ea+eb-127 in 11-bit signed arithmetic; a negative result SHALL be output as 0.
REQ-018 SHALL output exp_sum=0 and mant_prod=0 when either operand is zero; zero takes priority over special.
REQ-019 SHALL output exp_sum=300 and mant_prod=0 when either operand is special and neither is zero, so downstream saturates to Inf.
REQ-020 SHALL raise out_valid on the (24/BITS_PER_CYCLE + 1)th rising edge after the accept edge for a normal x normal product.
REQ-021 SHALL hold out_valid, sign, exp_sum and mant_prod stable in DONE until out_ready is sampled high.
REQ-022 SHALL drop out_valid on the edge where it samples out_ready high.
REQ-023 SHALL keep in_ready low during CALC and DONE, so no accept occurs in the DONE->IDLE cycle.
REQ-024 SHALL ignore changes on a, b and in_valid outside an accept edge.

Reset
REQ-025 SHALL, while rst_n is low, force state=IDLE, out_valid=0, sign=0, exp_sum=0, mant_prod=0, the iteration counter and partial product to 0, and in_ready=1.
REQ-026 SHALL, when rst_n is asserted mid-CALC or in DONE, abandon the operation with no output produced.

Configuration
REQ-027 SHALL use macro MULT_SEQ_EARLY_EXIT_EN to control special-case latency.
REQ-028 SHALL, when MULT_SEQ_EARLY_EXIT_EN is defined, send zero and special operands IDLE->DONE directly, with out_valid on the first edge after accept.
REQ-029 SHALL, when MULT_SEQ_EARLY_EXIT_EN is undefined, run zero and special operands through full CALC with the forced result, so latency is constant.

Structure
REQ-030 SHALL take from shared package mult_pkg: FSM state enum, BIAS=127, EXP_SPECIAL=300, MANT_W=24, PROD_W=48.
REQ-031 SHALL instantiate combinational sub-module mult_unpack, once per operand, to split sign/exponent/fraction, insert the hidden bit and flag zero or special.

Verification (BITS_PER_CYCLE=1 unless noted)
REQ-032 SHALL cover: a=0x3F800000, b=0x3F800000 -> sign=0, exp_sum=127, mant_prod=0x400000000000, out_valid 25 edges after accept.
REQ-033 SHALL cover: a=0x3FC00000, b=0x3FC00000 -> exp_sum=127, mant_prod=0x900000000000; with BITS_PER_CYCLE=4, out_valid 7 edges after accept.
REQ-034 SHALL cover: a=0xC0000000, b=0x40400000 -> sign=1, exp_sum=129, mant_prod=0x600000000000.
REQ-035 SHALL cover: a=0x00000000, b=0x7F800000 -> exp_sum=0, mant_prod=0, with latency 1 with the macro defined and 25 without.
REQ-036 SHALL cover: a=b=0x00800000 -> exp_sum=0; then out_ready held low 5 cycles -> outputs stable, in_ready=0.
REQ-037 SHALL cover: rst_n pulsed low at CALC cycle 10 -> out_valid=0, in_ready=1 immediately, and a new accept then completes correctly.
